// File: rtl/mem_access_pkg.sv
// Shared definitions for the SRAM access controller.
//   state_e   : controller FSM states
//   WaitCntW  : width of the access-phase wait counter
//   MemRead / MemWrite : encoding of the memory read_write pin
package mem_access_pkg;

  localparam int unsigned WaitCntW = 4;

  localparam logic MemRead  = 1'b0;
  localparam logic MemWrite = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StRecover
  } state_e;

endpackage

// File: rtl/mem_access_ctrl.sv
// Initiator for a single-port, asynchronous-read SRAM. Takes one read or write request at a
// time over a valid/ready handshake, drives the memory pins through setup, access and recovery
// phases, and returns read data or a write acknowledge over a response handshake.
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   req_valid_i / req_ready_o   request handshake
//   req_write_i, req_addr_i, req_wdata_i   request payload (1 = write)
//   resp_valid_o / resp_ready_i response handshake
//   resp_write_o, resp_rdata_o  echo of the request type and read data (0 for writes)
//   mem_address_o, mem_data_in_o, mem_read_write_o, mem_chip_en_o   memory pins (outputs)
//   mem_data_out_i              memory read data
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic              resp_write_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_data_in_o,
  input  logic [DATA_W-1:0] mem_data_out_i,
  output logic              mem_read_write_o,
  output logic              mem_chip_en_o
);

  if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : gen_bad_access_cycles
    $error("mem_access_ctrl: ACCESS_CYCLES must be in the range 1..15");
  end

  localparam logic [WaitCntW-1:0] CntLoad = WaitCntW'(ACCESS_CYCLES - 1);

  state_e              state_q, state_d;
  logic [WaitCntW-1:0] cnt_q, cnt_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_write_q, resp_write_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rw_q, rw_d;
  logic                ce_q, ce_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_write_d = resp_write_q;
    resp_rdata_d = resp_rdata_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rw_d         = rw_q;
    ce_d         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid_i && req_ready_q) begin
          addr_d       = req_addr_i;
          wdata_d      = req_wdata_i;
          rw_d         = req_write_i;
          resp_write_d = req_write_i;
          req_ready_d  = 1'b0;
          state_d      = StSetup;
        end
      end
      StSetup: begin
        // Pins have been stable for a full cycle; open the strobe on this edge.
        cnt_d   = CntLoad;
        ce_d    = 1'b1;
        state_d = StAccess;
      end
      StAccess: begin
        if (cnt_q == '0) begin
          resp_rdata_d = (rw_q == MemWrite) ? '0 : mem_data_out_i;
          resp_valid_d = 1'b1;
          state_d      = StRecover;
        end else begin
          cnt_d = cnt_q - 1'b1;
          ce_d  = 1'b1;
        end
      end
      StRecover: begin
        // Address and read_write stay put until the client takes the response, so the
        // strobe can never overlap an address change.
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          rw_d         = MemRead;
          req_ready_d  = 1'b1;
          state_d      = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Asynchronous reset drops chip_en and read_write immediately so a reset mid-access can
  // never complete a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      resp_rdata_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rw_q         <= MemRead;
      ce_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_write_q <= resp_write_d;
      resp_rdata_q <= resp_rdata_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rw_q         <= rw_d;
      ce_q         <= ce_d;
    end
  end

  assign req_ready_o      = req_ready_q;
  assign resp_valid_o     = resp_valid_q;
  assign resp_write_o     = resp_write_q;
  assign resp_rdata_o     = resp_rdata_q;
  assign mem_address_o    = addr_q;
  assign mem_data_in_o    = wdata_q;
  assign mem_read_write_o = rw_q;
  assign mem_chip_en_o    = ce_q;

endmodule
